timer_dev: RTL and testbench
============================

# timer_dev

Memory-mapped countdown timer on the data bus, downstream of the store byte-enable stage. It consumes the word-aligned address, byte enables and write data that stage produces, holds CTRL/PRESET/COUNT registers, counts down once per cycle, and raises an interrupt request toward the CP0 hardware-interrupt inputs. The design instantiates two copies, at 0x7f00 and 0x7f10.

## Interface
- `BASE`, 32'h0000_7f00: base address; the block decodes `BASE`..`BASE+0xb`.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `addr`  in  32  bus address.
- `byteen`  in  4  byte enables from the store stage; 4'b0000 means no write.
- `wdata`  in  32  bus write data.
- `rdata`  out  32  read data, combinational from `addr`.
- `irq`  out  1  interrupt request, registered.

## Operation
- Register map, with offsets from `BASE`:
  - +0x0 CTRL. Bit 0 is EN, bits [2:1] are MODE, bit 3 is IM. Bits [31:4] read as 0.
  - +0x4 PRESET, 32-bit.
  - +0x8 COUNT, read-only.
- Write strobe `we` = (`addr[31:4]` == `BASE[31:4]`) and (`byteen` == 4'b1111).
  - Partial byteen, offset 0x8, and offsets 0xc–0xf: no write occurs. The upstream stage already flags these as AdES.
  - Only `wdata[3:0]` is stored on a CTRL write.
- Read mux selects on `addr[3:2]`: 0 → CTRL, 1 → PRESET, 2 → COUNT, 3 → 0. Outside the window, `rdata` = 0.
- FSM states are IDLE, LOAD, CNT, INT. Transitions are evaluated on register values before the edge:
  - IDLE: EN=1 → LOAD; otherwise stay.
  - LOAD: COUNT ← PRESET, → CNT.
  - CNT: EN=0 → IDLE with COUNT held. Else, if COUNT ≤ 1: COUNT ← 0, irq_flag ← 1, → INT. Else COUNT ← COUNT−1.
  - INT with MODE=0 (one-shot): EN ← 0, → IDLE; irq_flag stays 1.
  - INT with MODE=1 (auto-reload): → LOAD; irq_flag ← 0.
  - MODE 2/3 behave as MODE 0.
- irq_flag clears on any CTRL write. In MODE 1 it is 1 for exactly one cycle per period.
- `irq` = irq_flag & IM, registered (one flop after irq_flag).
- PRESET written during CNT takes effect only at the next LOAD.
- Simultaneous events:
  - A bus CTRL write in the same cycle as the MODE-0 INT auto-clear of EN: the bus write wins. EN takes `wdata[0]`, and the state still goes to IDLE.
  - A bus CTRL write in the same cycle irq_flag would be set: the flag is set (set wins over clear).
- Reset values: CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0, `irq`=0. Reset mid-count aborts immediately with no irq.

## Timing
- CTRL write with EN=1 is captured at edge E0.
- E1: IDLE → LOAD.
- E2: COUNT=PRESET=N, state CNT.
- E2+k: COUNT=N−k. At E2+N (N ≥ 1): COUNT=0, state INT, irq_flag=1.
- `irq` is visible after E3+N.
- PRESET=0 and PRESET=1 both reach INT at E3 / E3+0 respectively, i.e. the first CNT edge.
- MODE 1 period = N+2 cycles (LOAD, N×CNT, INT), N ≥ 1.
- Clearing EN in CNT freezes COUNT; re-enabling restarts via LOAD, not a resume.
- `rdata` has zero latency and reflects post-edge register values.

## Test plan
- Reset, then read 0x7f00/0x7f04/0x7f08 → all 0 and `irq`=0.
- PRESET=5, CTRL=0x9 (EN, MODE 0, IM) → COUNT reads 5,4,3,2,1,0 on consecutive cycles after LOAD. `irq` rises 1 cycle after COUNT=0 and stays 1. CTRL reads 0x8 (EN auto-cleared). Writing CTRL=0 drops `irq` next cycle.
- PRESET=3, CTRL=0xb (MODE 1, IM) → `irq` pulses 1 cycle wide every 5 cycles. COUNT sequence is 3,2,1,0 then reloads to 3.
- Writes with byteen=4'b0011 to CTRL, and sw to 0x7f08 → CTRL/COUNT unchanged. Writes with addr 0x7f10 to the BASE=0x7f00 instance → ignored.
- PRESET=100, run 10 cycles, write EN=0 → COUNT frozen at 100−9. Re-enable → COUNT reloads to 100.
- Reset asserted (low) mid-count with PRESET=50 → next edge: COUNT=0, state IDLE, `irq`=0. CTRL=0 after release.

Source files
------------

// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer with interrupt request.
//
// Register map (offsets from BASE):
//   +0x0 CTRL   [0]=EN, [2:1]=MODE, [3]=IM, [31:4] read as 0
//   +0x4 PRESET 32-bit reload value
//   +0x8 COUNT  read-only current count
//   +0xc        reads 0
//
// Ports:
//   clk    - clock, all state changes on rising edge
//   reset  - synchronous, active-low reset
//   addr   - word-aligned bus address
//   byteen - store byte enables; only a full-word store (4'b1111) writes
//   wdata  - bus write data
//   rdata  - combinational read data for addr (0 outside the window)
//   irq    - registered interrupt request (irq_flag & IM)
module timer_dev #(
  parameter logic [31:0] BASE = 32'h0000_7f00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CNT,
    INT
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic [31:0] count_nx;
  logic        irq_flag;
  logic        en_clr;
  logic        flag_set;
  logic        flag_clr;

  logic        sel;
  logic        we;
  logic        ctrl_we;
  logic        preset_we;

  // Byte offset bits are irrelevant for a word-aligned register file.
  logic        unused_addr_bits;
  assign unused_addr_bits = ^addr[1:0];

  assign sel       = (addr[31:4] == BASE[31:4]);
  assign we        = sel && (byteen == 4'b1111);
  assign ctrl_we   = we && (addr[3:2] == 2'd0);
  assign preset_we = we && (addr[3:2] == 2'd1);

  always_comb begin
    rdata = '0;
    if (sel) begin
      unique case (addr[3:2])
        2'd0:    rdata = {28'd0, ctrl};
        2'd1:    rdata = preset;
        2'd2:    rdata = count;
        default: rdata = '0;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    en_clr   = 1'b0;
    flag_set = 1'b0;
    flag_clr = 1'b0;
    unique case (state)
      IDLE: begin
        if (ctrl[0]) state_nx = LOAD;
      end
      LOAD: begin
        count_nx = preset;
        state_nx = CNT;
      end
      CNT: begin
        if (!ctrl[0]) begin
          state_nx = IDLE;
        end else if (count <= 32'd1) begin
          count_nx = '0;
          flag_set = 1'b1;
          state_nx = INT;
        end else begin
          count_nx = count - 32'd1;
        end
      end
      INT: begin
        if (ctrl[2:1] == 2'b01) begin
          flag_clr = 1'b1;
          state_nx = LOAD;
        end else begin
          en_clr   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
      irq      <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      // A bus CTRL write overrides the one-shot EN auto-clear.
      if (ctrl_we) begin
        ctrl <= wdata[3:0];
      end else if (en_clr) begin
        ctrl[0] <= 1'b0;
      end
      if (preset_we) preset <= wdata;
      // Setting the flag takes priority over any clear in the same cycle.
      if (flag_set) begin
        irq_flag <= 1'b1;
      end else if (ctrl_we || flag_clr) begin
        irq_flag <= 1'b0;
      end
      irq <= irq_flag & ctrl[3];
    end
  end

endmodule

// File: tb/tb_timer_dev.sv
// Directed self-checking bench for timer_dev (BASE = 0x7f00).
module tb_timer_dev;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int unsigned n_checks;
  int unsigned n_fail;

  localparam logic [31:0] A_CTRL   = 32'h0000_7f00;
  localparam logic [31:0] A_PRESET = 32'h0000_7f04;
  localparam logic [31:0] A_COUNT  = 32'h0000_7f08;

  timer_dev #(.BASE(32'h0000_7f00)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bus store captured at the next rising edge.
  task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    addr   = a;
    byteen = be;
    wdata  = d;
    step();
    byteen = 4'b0000;
  endtask

  task automatic rchk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  // MODE 1, PRESET=3: COUNT and irq after edges E1..E15
  logic [31:0] m1_count [15] = '{0, 3, 2, 1, 0, 0, 3, 2, 1, 0, 0, 3, 2, 1, 0};
  logic        m1_irq   [15] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0};

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    addr     = '0;
    byteen   = 4'b0000;
    wdata    = '0;
    #2;
    do_reset();

    // Reset state
    rchk("rst_ctrl", A_CTRL, 32'd0);
    rchk("rst_preset", A_PRESET, 32'd0);
    rchk("rst_count", A_COUNT, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);

    // One-shot, PRESET=5, IM set
    wr(A_PRESET, 4'b1111, 32'd5);
    rchk("os_preset", A_PRESET, 32'd5);
    wr(A_CTRL, 4'b1111, 32'h9);            // E0
    rchk("os_ctrl", A_CTRL, 32'h9);
    step();                                // E1 LOAD
    rchk("os_count_e1", A_COUNT, 32'd0);
    step();                                // E2
    rchk("os_count_e2", A_COUNT, 32'd5);
    for (int k = 1; k <= 5; k++) begin
      step();
      rchk($sformatf("os_count_e%0d", k + 2), A_COUNT, 32'd5 - 32'(k));
    end
    check("os_irq_e7", {31'd0, irq}, 32'd0);
    step();                                // E8
    check("os_irq_e8", {31'd0, irq}, 32'd1);
    rchk("os_ctrl_autoclr", A_CTRL, 32'h8);
    step();
    step();
    check("os_irq_hold", {31'd0, irq}, 32'd1);
    wr(A_CTRL, 4'b1111, 32'h0);
    check("os_irq_wclr0", {31'd0, irq}, 32'd1);
    step();
    check("os_irq_wclr1", {31'd0, irq}, 32'd0);

    // Auto-reload, PRESET=3
    wr(A_PRESET, 4'b1111, 32'd3);
    wr(A_CTRL, 4'b1111, 32'hb);            // E0
    for (int c = 0; c < 15; c++) begin
      step();
      rchk($sformatf("ar_count_e%0d", c + 1), A_COUNT, m1_count[c]);
      check($sformatf("ar_irq_e%0d", c + 1), {31'd0, irq}, {31'd0, m1_irq[c]});
    end
    wr(A_CTRL, 4'b1111, 32'h0);            // E16, state was INT
    check("ar_irq_e16", {31'd0, irq}, 32'd1);
    step();
    check("ar_irq_e17", {31'd0, irq}, 32'd0);
    step();
    step();
    step();
    rchk("ar_count_stop", A_COUNT, 32'd3);
    check("ar_irq_stop", {31'd0, irq}, 32'd0);

    // Ignored writes
    do_reset();
    wr(A_CTRL, 4'b0011, 32'h1);
    rchk("pw_ctrl", A_CTRL, 32'd0);
    wr(A_PRESET, 4'b1100, 32'h1234);
    rchk("pw_preset", A_PRESET, 32'd0);
    wr(A_COUNT, 4'b1111, 32'h1234);
    rchk("sw_count", A_COUNT, 32'd0);
    wr(32'h0000_7f0c, 4'b1111, 32'h55);
    rchk("rd_0c", 32'h0000_7f0c, 32'd0);
    wr(32'h0000_7f10, 4'b1111, 32'h9);
    wr(32'h0000_7f14, 4'b1111, 32'h77);
    rchk("oow_rdata", 32'h0000_7f10, 32'd0);
    rchk("oow_ctrl", A_CTRL, 32'd0);
    rchk("oow_preset", A_PRESET, 32'd0);
    step();
    step();
    rchk("oow_count", A_COUNT, 32'd0);

    // PRESET=0 reaches INT on first CNT edge
    wr(A_CTRL, 4'b1111, 32'h9);            // E0
    step();
    step();                                // E2
    rchk("p0_count_e2", A_COUNT, 32'd0);
    step();                                // E3 INT
    check("p0_irq_e3", {31'd0, irq}, 32'd0);
    step();                                // E4
    check("p0_irq_e4", {31'd0, irq}, 32'd1);
    rchk("p0_ctrl_e4", A_CTRL, 32'h8);
    wr(A_CTRL, 4'b1111, 32'h0);
    step();
    check("p0_irq_clr", {31'd0, irq}, 32'd0);

    // PRESET=1, bus CTRL write during one-shot INT wins over EN clear
    wr(A_PRESET, 4'b1111, 32'd1);
    wr(A_CTRL, 4'b1111, 32'h9);            // E0
    step();
    step();                                // E2
    rchk("p1_count_e2", A_COUNT, 32'd1);
    step();                                // E3 INT
    rchk("p1_count_e3", A_COUNT, 32'd0);
    check("p1_irq_e3", {31'd0, irq}, 32'd0);
    wr(A_CTRL, 4'b1111, 32'h9);            // E4
    rchk("bw_ctrl_e4", A_CTRL, 32'h9);
    check("bw_irq_e4", {31'd0, irq}, 32'd1);
    step();                                // E5 LOAD
    check("bw_irq_e5", {31'd0, irq}, 32'd0);
    step();                                // E6 CNT, COUNT=1
    rchk("bw_count_e6", A_COUNT, 32'd1);
    // CTRL write in the cycle the flag gets set: set wins
    wr(A_CTRL, 4'b1111, 32'h8);            // E7
    rchk("sw_ctrl_e7", A_CTRL, 32'h8);
    check("sw_irq_e7", {31'd0, irq}, 32'd0);
    step();                                // E8
    check("sw_irq_e8", {31'd0, irq}, 32'd1);
    step();
    check("sw_irq_e9", {31'd0, irq}, 32'd1);
    wr(A_CTRL, 4'b1111, 32'h0);
    step();
    check("sw_irq_clr", {31'd0, irq}, 32'd0);

    // Freeze and restart
    wr(A_PRESET, 4'b1111, 32'd100);
    wr(A_CTRL, 4'b1111, 32'h1);            // E0
    repeat (10) step();                    // E10
    wr(A_CTRL, 4'b1111, 32'h0);            // E11
    rchk("fz_count_e11", A_COUNT, 32'd91);
    repeat (3) step();
    rchk("fz_count_hold", A_COUNT, 32'd91);
    rchk("fz_ctrl", A_CTRL, 32'd0);
    wr(A_CTRL, 4'b1111, 32'h1);            // Er
    step();                                // Er+1 LOAD
    rchk("re_count_r1", A_COUNT, 32'd91);
    step();                                // Er+2
    rchk("re_count_r2", A_COUNT, 32'd100);

    // Reset mid-count
    wr(A_CTRL, 4'b1111, 32'h0);
    wr(A_PRESET, 4'b1111, 32'd50);
    wr(A_CTRL, 4'b1111, 32'h9);            // E0
    repeat (5) step();                     // E5
    rchk("mr_count_e5", A_COUNT, 32'd47);
    reset = 1'b0;
    step();
    rchk("mr_count_rst", A_COUNT, 32'd0);
    rchk("mr_ctrl_rst", A_CTRL, 32'd0);
    rchk("mr_preset_rst", A_PRESET, 32'd0);
    check("mr_irq_rst", {31'd0, irq}, 32'd0);
    reset = 1'b1;
    repeat (4) step();
    rchk("mr_count_after", A_COUNT, 32'd0);
    rchk("mr_ctrl_after", A_CTRL, 32'd0);
    check("mr_irq_after", {31'd0, irq}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
